// File: rtl/netlist_bist_wrapper_if.sv
// Bus between the BIST wrapper and whoever controls it.
// The controller (master) launches/aborts sessions, supplies the golden
// signature and feeds back the netlist outputs; the wrapper (slave) returns
// patterns and session status.
interface netlist_bist_wrapper_if #(
  parameter int PAT_W  = 14,
  parameter int RESP_W = 8
);
  logic              start;
  logic              abort;
  logic [RESP_W-1:0] golden;
  logic [RESP_W-1:0] resp_in;
  logic [PAT_W-1:0]  pat_out;
  logic              pat_valid;
  logic              busy;
  logic              done;
  logic              pass;
  logic [RESP_W-1:0] signature;

  modport master (
    output start, abort, golden, resp_in,
    input  pat_out, pat_valid, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, golden, resp_in,
    output pat_out, pat_valid, busy, done, pass, signature
  );
endinterface

// File: rtl/netlist_bist_wrapper.sv
// BIST harness around a flattened combinational netlist: a 14-bit LFSR
// drives the netlist inputs, an 8-bit MISR compacts its outputs, and a
// four-state FSM runs a fixed-length session and compares the final
// signature against a golden value.
module netlist_bist_wrapper #(
  parameter int                PAT_W        = 14,
  parameter int                RESP_W       = 8,
  parameter int                NUM_PATTERNS = 1024,
  parameter logic [PAT_W-1:0]  SEED         = 14'h0001,
  parameter logic [RESP_W-1:0] MISR_POLY    = 8'h1D,
  parameter int                RESP_LAT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  netlist_bist_wrapper_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PAT_W-1:0] SEED_EFF   = (SEED == '0) ? PAT_W'(1) : SEED;
  localparam logic [15:0]      LAST_PAT   = 16'(NUM_PATTERNS - 1);
  localparam logic [15:0]      LAST_DRAIN = (RESP_LAT == 0) ? 16'd0 : 16'(RESP_LAT - 1);

  state_t            state, state_next;
  logic              launch;
  logic [15:0]       count;
  logic [PAT_W-1:0]  pat_q;
  logic              pat_valid_q;
  logic [RESP_W-1:0] misr;
  logic              resp_valid;

  wire               lfsr_fb   = pat_q[PAT_W-1] ^ pat_q[PAT_W-2] ^ pat_q[PAT_W-3] ^ pat_q[1];
  wire [PAT_W-1:0]   lfsr_next = {pat_q[PAT_W-2:0], lfsr_fb};
  wire [RESP_W-1:0]  misr_next = {misr[RESP_W-2:0], 1'b0}
                               ^ (misr[RESP_W-1] ? MISR_POLY : '0)
                               ^ bus.resp_in;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort overrides every transition.
  // NOTE: every output of this block gets a default first, otherwise a
  // path that skips an assignment infers a latch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (bus.start) begin
          state_next = RUN;
          launch     = 1'b1;
        end
        RUN:   if (count == LAST_PAT) state_next = (RESP_LAT == 0) ? DONE : DRAIN;
        DRAIN: if (count == LAST_DRAIN) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pattern generator and shared pattern/drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q       <= '0;
      pat_valid_q <= 1'b0;
      count       <= '0;
    end else if (bus.abort) begin
      pat_valid_q <= 1'b0;
      count       <= '0;
    end else if (launch) begin
      pat_q       <= SEED_EFF;
      pat_valid_q <= 1'b1;
      count       <= '0;
    end else if (state == RUN) begin
      pat_q <= lfsr_next;
      if (count == LAST_PAT) begin
        pat_valid_q <= 1'b0;
        count       <= '0;
      end else begin
        count <= count + 16'd1;
      end
    end else if (state == DRAIN) begin
      count <= count + 16'd1;
    end
  end

  // Response-valid alignment: pat_valid delayed by RESP_LAT stages.
  if (RESP_LAT == 0) begin : g_no_lat
    assign resp_valid = pat_valid_q;
  end else begin : g_lat
    logic [RESP_LAT-1:0] valid_pipe;

    // Shift pat_valid through the delay line; abort flushes it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            valid_pipe <= '0;
      else if (bus.abort) valid_pipe <= '0;
      else                valid_pipe <= (valid_pipe << 1) | RESP_LAT'(pat_valid_q);
    end

    assign resp_valid = valid_pipe[RESP_LAT-1];
  end

  // MISR: cleared on launch, compacts aligned responses, frozen otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          misr <= '0;
    else if (launch)                  misr <= '0;
    else if (resp_valid && !bus.abort) misr <= misr_next;
  end

  assign bus.pat_out   = pat_q;
  assign bus.pat_valid = pat_valid_q;
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (misr == bus.golden);
  assign bus.signature = misr;

endmodule

// File: tb/tb_netlist_bist_wrapper.sv
// Directed bench for netlist_bist_wrapper. Four instances cover the
// parameter points of interest: (N=3,LAT=0), (N=1,LAT=0), (N=2,LAT=0),
// (N=2,LAT=2). Inputs change 1 ns after a rising edge; outputs are checked
// at that same point, well away from the next edge.
module tb_netlist_bist_wrapper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  netlist_bist_wrapper_if #(.PAT_W(14), .RESP_W(8)) if_a ();
  netlist_bist_wrapper_if #(.PAT_W(14), .RESP_W(8)) if_b ();
  netlist_bist_wrapper_if #(.PAT_W(14), .RESP_W(8)) if_c ();
  netlist_bist_wrapper_if #(.PAT_W(14), .RESP_W(8)) if_d ();

  netlist_bist_wrapper #(.NUM_PATTERNS(3), .RESP_LAT(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  netlist_bist_wrapper #(.NUM_PATTERNS(1), .RESP_LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  netlist_bist_wrapper #(.NUM_PATTERNS(2), .RESP_LAT(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  netlist_bist_wrapper #(.NUM_PATTERNS(2), .RESP_LAT(2)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

  // Status nibbles {pat_valid, busy, done, pass}.
  wire [3:0] st_a = {if_a.pat_valid, if_a.busy, if_a.done, if_a.pass};
  wire [3:0] st_b = {if_b.pat_valid, if_b.busy, if_b.done, if_b.pass};
  wire [3:0] st_c = {if_c.pat_valid, if_c.busy, if_c.done, if_c.pass};
  wire [3:0] st_d = {if_d.pat_valid, if_d.busy, if_d.done, if_d.pass};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (st_a !== 4'b0000) begin $display("FAIL reset_status_a got=%b exp=0000", st_a); failures++; end
    checks++;
    if (if_a.pat_out !== 14'h0000) begin $display("FAIL reset_pat_a got=%h exp=0000", if_a.pat_out); failures++; end
    checks++;
    if (if_a.signature !== 8'h00) begin $display("FAIL reset_sig_a got=%h exp=00", if_a.signature); failures++; end
    checks++;
    if ({st_b, st_c, st_d} !== 12'h000) begin $display("FAIL reset_status_bcd got=%h exp=000", {st_b, st_c, st_d}); failures++; end
    checks++;
  endtask

  // SEED=1, N=3: patterns 0001, 0002, 0005, then done 3 edges after launch.
  task automatic test_lfsr_sequence();
    logic [13:0] exp_pat [3];
    exp_pat[0] = 14'h0001; exp_pat[1] = 14'h0002; exp_pat[2] = 14'h0005;
    if_a.resp_in = 8'h00; if_a.golden = 8'h00; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (if_a.pat_out !== exp_pat[i]) begin $display("FAIL lfsr_pat[%0d] got=%h exp=%h", i, if_a.pat_out, exp_pat[i]); failures++; end
      checks++;
      if (st_a !== 4'b1100) begin $display("FAIL lfsr_status[%0d] got=%b exp=1100", i, st_a); failures++; end
      checks++;
      step();
    end
    if (st_a !== 4'b0011) begin $display("FAIL lfsr_done got=%b exp=0011", st_a); failures++; end
    checks++;
  endtask

  // N=1 with resp FF: one pattern (the seed), signature FF, pass.
  task automatic test_single_pattern();
    if_b.resp_in = 8'hFF; if_b.golden = 8'hFF; if_b.start = 1'b1;
    step();
    if_b.start = 1'b0;
    if ({st_b, 2'b00, if_b.pat_out} !== {4'b1100, 16'h0001}) begin
      $display("FAIL single_run got=%b/%h exp=1100/0001", st_b, if_b.pat_out); failures++;
    end
    checks++;
    step();
    if ({st_b, if_b.signature} !== {4'b0011, 8'hFF}) begin
      $display("FAIL single_done got=%b/%h exp=0011/ff", st_b, if_b.signature); failures++;
    end
    checks++;
  endtask

  // N=2 with resp FF: signature 00 -> FF -> 1C; pass tracks golden; frozen.
  task automatic test_misr_two();
    if_c.resp_in = 8'hFF; if_c.golden = 8'h1C; if_c.start = 1'b1;
    step();
    if_c.start = 1'b0;
    if (if_c.signature !== 8'h00) begin $display("FAIL misr_clear got=%h exp=00", if_c.signature); failures++; end
    checks++;
    step();
    if ({st_c, if_c.signature} !== {4'b1100, 8'hFF}) begin
      $display("FAIL misr_first got=%b/%h exp=1100/ff", st_c, if_c.signature); failures++;
    end
    checks++;
    step();
    if ({st_c, if_c.signature} !== {4'b0011, 8'h1C}) begin
      $display("FAIL misr_second got=%b/%h exp=0011/1c", st_c, if_c.signature); failures++;
    end
    checks++;
    if_c.golden = 8'h1D;
    #1;
    if (st_c !== 4'b0010) begin $display("FAIL misr_wrong_golden got=%b exp=0010", st_c); failures++; end
    checks++;
    step();
    if ({st_c, if_c.signature} !== {4'b0010, 8'h1C}) begin
      $display("FAIL misr_frozen got=%b/%h exp=0010/1c", st_c, if_c.signature); failures++;
    end
    checks++;
  endtask

  // LAT=2, N=2: responses sampled at launch+3 and launch+4, done at launch+4.
  task automatic test_resp_latency();
    int busy_cycles = 0;
    if_d.resp_in = 8'h00; if_d.golden = 8'h1C; if_d.start = 1'b1;
    step();                                   // launch+1 ns
    if_d.start = 1'b0;
    if ({st_d, 2'b00, if_d.pat_out} !== {4'b1100, 16'h0001}) begin
      $display("FAIL lat_launch got=%b/%h exp=1100/0001", st_d, if_d.pat_out); failures++;
    end
    checks++;
    busy_cycles += int'(if_d.busy);
    step();                                   // edge 1
    busy_cycles += int'(if_d.busy);
    step();                                   // edge 2: DRAIN, aligned window opens
    if (st_d !== 4'b0100) begin $display("FAIL lat_drain got=%b exp=0100", st_d); failures++; end
    checks++;
    busy_cycles += int'(if_d.busy);
    if_d.resp_in = 8'hFF;
    step();                                   // edge 3
    if ({st_d, if_d.signature} !== {4'b0100, 8'hFF}) begin
      $display("FAIL lat_first got=%b/%h exp=0100/ff", st_d, if_d.signature); failures++;
    end
    checks++;
    busy_cycles += int'(if_d.busy);
    step();                                   // edge 4
    if_d.resp_in = 8'hAA;
    if ({st_d, if_d.signature} !== {4'b0011, 8'h1C}) begin
      $display("FAIL lat_done got=%b/%h exp=0011/1c", st_d, if_d.signature); failures++;
    end
    checks++;
    if (busy_cycles !== 4) begin $display("FAIL lat_busy_cycles got=%0d exp=4", busy_cycles); failures++; end
    checks++;
    step();
    if (if_d.signature !== 8'h1C) begin $display("FAIL lat_frozen got=%h exp=1c", if_d.signature); failures++; end
    checks++;
  endtask

  // Abort on the 2nd RUN cycle, then a clean run with resp 3C -> B4.
  task automatic test_abort();
    if_a.resp_in = 8'h3C; if_a.golden = 8'h00; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    step();
    if (if_a.signature !== 8'h3C) begin $display("FAIL abort_pre_sig got=%h exp=3c", if_a.signature); failures++; end
    checks++;
    if_a.abort = 1'b1;
    step();
    if_a.abort = 1'b0;
    if ({st_a, if_a.signature} !== {4'b0000, 8'h3C}) begin
      $display("FAIL abort_idle got=%b/%h exp=0000/3c", st_a, if_a.signature); failures++;
    end
    checks++;
    step();
    if ({st_a, if_a.signature} !== {4'b0000, 8'h3C}) begin
      $display("FAIL abort_hold got=%b/%h exp=0000/3c", st_a, if_a.signature); failures++;
    end
    checks++;
    if_a.golden = 8'hB4; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    if ({if_a.signature, 2'b00, if_a.pat_out} !== {8'h00, 16'h0001}) begin
      $display("FAIL abort_relaunch got=%h/%h exp=00/0001", if_a.signature, if_a.pat_out); failures++;
    end
    checks++;
    step(); step(); step();
    if ({st_a, if_a.signature} !== {4'b0011, 8'hB4}) begin
      $display("FAIL abort_clean_run got=%b/%h exp=0011/b4", st_a, if_a.signature); failures++;
    end
    checks++;
  endtask

  // Async reset mid-RUN clears every output before the next edge.
  task automatic test_async_reset();
    if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    if ({st_a, 2'b00, if_a.pat_out, if_a.signature} !== 32'h0) begin
      $display("FAIL async_rst got=%b/%h/%h exp=0000/0000/00", st_a, if_a.pat_out, if_a.signature); failures++;
    end
    checks++;
    rst = 1'b0;
    step();
    if (st_a !== 4'b0000) begin $display("FAIL async_rst_idle got=%b exp=0000", st_a); failures++; end
    checks++;
  endtask

  // start held high: ignored while busy, relaunches straight out of DONE.
  task automatic test_back_to_back();
    logic [13:0] exp_pat [6];
    logic [7:0]  exp_sig [6];
    logic [3:0]  exp_st  [6];
    exp_pat = '{14'h0001, 14'h0002, 14'h0000, 14'h0001, 14'h0002, 14'h0000};
    exp_sig = '{8'h00, 8'hFF, 8'h1C, 8'h00, 8'hFF, 8'h1C};
    exp_st  = '{4'b1100, 4'b1100, 4'b0011, 4'b1100, 4'b1100, 4'b0011};
    if_c.resp_in = 8'hFF; if_c.golden = 8'h1C; if_c.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if ({st_c, if_c.signature} !== {exp_st[i], exp_sig[i]}) begin
        $display("FAIL b2b_status[%0d] got=%b/%h exp=%b/%h", i, st_c, if_c.signature, exp_st[i], exp_sig[i]); failures++;
      end
      checks++;
      if (exp_st[i][3] && if_c.pat_out !== exp_pat[i]) begin
        $display("FAIL b2b_pat[%0d] got=%h exp=%h", i, if_c.pat_out, exp_pat[i]); failures++;
      end
      checks++;
    end
    if_c.start = 1'b0;
    step();
    if ({st_c, if_c.signature} !== {4'b0011, 8'h1C}) begin
      $display("FAIL b2b_hold got=%b/%h exp=0011/1c", st_c, if_c.signature); failures++;
    end
    checks++;
  endtask

  initial begin
    if_a.start = 1'b0; if_a.abort = 1'b0; if_a.golden = '0; if_a.resp_in = '0;
    if_b.start = 1'b0; if_b.abort = 1'b0; if_b.golden = '0; if_b.resp_in = '0;
    if_c.start = 1'b0; if_c.abort = 1'b0; if_c.golden = '0; if_c.resp_in = '0;
    if_d.start = 1'b0; if_d.abort = 1'b0; if_d.golden = '0; if_d.resp_in = '0;
    #12;
    test_reset();
    rst = 1'b0;
    step();
    test_lfsr_sequence();
    test_single_pattern();
    test_misr_two();
    test_resp_latency();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
